// File: rtl/wfid_free_list.sv
// Wavefront-ID free list: circular buffer of free IDs plus an in-use bitmap.
// Resets full (IDs 0..NUM_WF-1); dispatcher pops at the head, retire pushes at the tail.
module wfid_free_list #(
   parameter int NUM_WF = 40,
   parameter int ID_W   = 6
) (
   input  logic            clk,
   input  logic            rst,
   output logic            alloc_valid,
   output logic [ID_W-1:0] alloc_wfid,
   input  logic            alloc_ack,
   input  logic            release_valid,
   input  logic [ID_W-1:0] release_wfid,
   output logic [6:0]      free_count,
   output logic            err_release,
   input  logic            err_clr
);

   localparam logic [ID_W-1:0] LAST = ID_W'(NUM_WF - 1);
   localparam logic [6:0]      FULL = 7'(NUM_WF);

   logic [ID_W-1:0]   mem_q [NUM_WF];
   logic [ID_W-1:0]   mem_d [NUM_WF];
   logic [ID_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ID_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [6:0]        count_q, count_d;
   logic [NUM_WF-1:0] in_use_q, in_use_d;
   logic              err_q, err_d;

   logic pop, push, in_range;

   assign alloc_valid = (count_q != 7'd0);
   assign alloc_wfid  = mem_q[rd_ptr_q];
   assign free_count  = count_q;
   assign err_release = err_q;

   assign pop      = alloc_ack & alloc_valid;
   assign in_range = 32'(release_wfid) < NUM_WF;
   // A free ID is never in use, so this also rejects releasing the head being popped.
   assign push     = release_valid & in_range & in_use_q[release_wfid]
                   & ~(pop & (alloc_wfid == release_wfid));

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      in_use_d = in_use_q;
      err_d    = err_q;

      if (pop) begin
         rd_ptr_d             = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
         in_use_d[alloc_wfid] = 1'b1;
      end

      if (push) begin
         mem_d[wr_ptr_q]        = release_wfid;
         wr_ptr_d               = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
         in_use_d[release_wfid] = 1'b0;
      end

      case ({pop, push})
         2'b10:   count_d = count_q - 7'd1;
         2'b01:   count_d = count_q + 7'd1;
         default: count_d = count_q;
      endcase

      if (err_clr) err_d = 1'b0;
      if (release_valid && !push) err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_WF; i++) mem_q[i] <= ID_W'(i);
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= FULL;
         in_use_q <= '0;
         err_q    <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         in_use_q <= in_use_d;
         err_q    <= err_d;
      end
   end

endmodule
